subleq_core_hs: RTL

- Parametrised next-generation SUBLEQ processor core.
- Executes `mem[B] = mem[B] - mem[A]`; if the result is <= 0 (signed), jumps to C, else PC += 3.
- Talks to memory over a variable-latency req/ack handshake instead of fixed single-cycle access.
- Adds configurable width, reset PC, halt address, run/pause control and a retired-instruction counter.

---
 rtl/subleq_core_hs.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/subleq_core_hs.sv
// SUBLEQ core: mem[B] -= mem[A]; branch to C when the result is <= 0.
// Memory is reached through a req/ack handshake whose latency is set by the memory.
module subleq_core_hs #(
  parameter int unsigned          WIDTH       = 16,
  parameter logic [WIDTH-1:0]     RESET_PC    = '0,
  parameter logic [WIDTH-1:0]     HALT_ADDR   = {WIDTH{1'b1}},
  parameter int unsigned          COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   areset,
  input  logic                   run_en,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [WIDTH-1:0]       mem_addr,
  output logic [WIDTH-1:0]       mem_wdata,
  input  logic [WIDTH-1:0]       mem_rdata,
  input  logic                   mem_ack,
  output logic [WIDTH-1:0]       pc,
  output logic                   halted,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_A,
    S_FETCH_B,
    S_FETCH_C,
    S_LOAD_A,
    S_LOAD_B,
    S_STORE,
    S_HALT
  } state_e;

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       pc_q, pc_d;
  logic [WIDTH-1:0]       a_q, a_d;
  logic [WIDTH-1:0]       b_q, b_d;
  logic [WIDTH-1:0]       c_q, c_d;
  logic [WIDTH-1:0]       vala_q, vala_d;
  logic [WIDTH-1:0]       valb_q, valb_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0]       diff;
  logic                   leq;
  logic [WIDTH-1:0]       pc_p1, pc_p2, pc_p3;

  // Difference wraps modulo 2^WIDTH; sign bit or all-zero means "<= 0".
  assign diff  = WIDTH'(valb_q - vala_q);
  assign leq   = diff[WIDTH-1] | ~(|diff);
  assign pc_p1 = WIDTH'(pc_q + WIDTH'(1));
  assign pc_p2 = WIDTH'(pc_q + WIDTH'(2));
  assign pc_p3 = WIDTH'(pc_q + WIDTH'(3));

  always_ff @(posedge clk) begin
    if (areset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      vala_q  <= '0;
      valb_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      vala_q  <= vala_d;
      valb_q  <= valb_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sequencing: every memory state advances only on its ack.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    vala_d  = vala_q;
    valb_d  = valb_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (run_en) state_d = S_FETCH_A;
      end
      S_FETCH_A: begin
        if (mem_ack) begin
          a_d     = mem_rdata;
          state_d = S_FETCH_B;
        end
      end
      S_FETCH_B: begin
        if (mem_ack) begin
          b_d     = mem_rdata;
          state_d = S_FETCH_C;
        end
      end
      S_FETCH_C: begin
        if (mem_ack) begin
          c_d     = mem_rdata;
          state_d = S_LOAD_A;
        end
      end
      S_LOAD_A: begin
        if (mem_ack) begin
          vala_d  = mem_rdata;
          state_d = S_LOAD_B;
        end
      end
      S_LOAD_B: begin
        if (mem_ack) begin
          valb_d  = mem_rdata;
          state_d = S_STORE;
        end
      end
      S_STORE: begin
        if (mem_ack) begin
          cnt_d = COUNT_WIDTH'(cnt_q + COUNT_WIDTH'(1));
          if (leq && (c_q == HALT_ADDR)) begin
            pc_d    = HALT_ADDR;
            state_d = S_HALT;
          end else begin
            pc_d    = leq ? c_q : pc_p3;
            state_d = run_en ? S_FETCH_A : S_IDLE;
          end
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
    endcase
  end

  // Bus outputs decoded from registered state so they hold steady while waiting.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      S_FETCH_A: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
      end
      S_FETCH_B: begin
        mem_req  = 1'b1;
        mem_addr = pc_p1;
      end
      S_FETCH_C: begin
        mem_req  = 1'b1;
        mem_addr = pc_p2;
      end
      S_LOAD_A: begin
        mem_req  = 1'b1;
        mem_addr = a_q;
      end
      S_LOAD_B: begin
        mem_req  = 1'b1;
        mem_addr = b_q;
      end
      S_STORE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = b_q;
        mem_wdata = diff;
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

  assign pc          = pc_q;
  assign halted      = (state_q == S_HALT);
  assign instr_count = cnt_q;

endmodule
